// File: rtl/wb_pkg.sv
// Shared pipeline types for the ALU->writeback boundary plus writeback-local
// state, redirect and flush-counter definitions.
package wb_pkg;

  localparam int IMM_W       = 32;
  localparam int REG_NUM_MAX = 16;
  localparam int REG_W       = $clog2(REG_NUM_MAX);
  localparam int FLUSH_CNT_W = 3;

  typedef logic [IMM_W-1:0] imm_t;
  typedef logic [REG_W-1:0] reg_t;

  typedef struct packed {
    logic wb_wr;
    reg_t reg_dst;
    logic pc_branch;
  } alu_fur_sig_t;

  typedef struct packed {
    imm_t         dst;
    alu_fur_sig_t fur_sig;
  } alu_to_wb_req_t;

  typedef enum logic {
    WB_RUN,
    WB_FLUSH
  } wb_state_t;

  typedef struct packed {
    logic redirect;
    imm_t target;
  } wb_to_fetch_redirect_t;

endpackage

// File: rtl/writeback_if.sv
// Bundle between the ALU/register-read stages and writeback: the incoming
// request plus the two register read ports.
interface writeback_if;
  import wb_pkg::*;

  alu_to_wb_req_t alu_to_wb_req;
  reg_t           rd_addr_1;
  reg_t           rd_addr_2;
  imm_t           rd_data_1;
  imm_t           rd_data_2;

  modport master (
    output alu_to_wb_req, rd_addr_1, rd_addr_2,
    input  rd_data_1, rd_data_2
  );

  modport slave (
    input  alu_to_wb_req, rd_addr_1, rd_addr_2,
    output rd_data_1, rd_data_2
  );
endinterface

// File: rtl/wb_regfile.sv
// Architectural register file: one synchronous write port, two combinational
// read ports that forward the same-cycle write; register 0 reads as zero.
module wb_regfile
  import wb_pkg::*;
#(
  parameter int REG_NUM = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic we_i,
  input  reg_t waddr_i,
  input  imm_t wdata_i,
  input  reg_t rd_addr_1_i,
  input  reg_t rd_addr_2_i,
  output imm_t rd_data_1_o,
  output imm_t rd_data_2_o
);

  imm_t regs_q [REG_NUM];
  logic wr_ok;

  assign wr_ok = we_i && (waddr_i != '0) && (int'(waddr_i) < REG_NUM);

  // NOTE: the array is cleared on reset because software may read any register
  // before writing it; a reset-less RAM macro would not give that guarantee.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  function automatic imm_t read_port(input reg_t addr);
    imm_t data;
    data = '0;
    if (addr != '0 && int'(addr) < REG_NUM) begin
      data = (wr_ok && waddr_i == addr) ? wdata_i : regs_q[addr];
    end
    return data;
  endfunction

  always_comb begin
    rd_data_1_o = read_port(rd_addr_1_i);
    rd_data_2_o = read_port(rd_addr_2_i);
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: registers the ALU result, commits it to the register
// file, converts branches into a one-cycle fetch redirect and squashes the wrong path.
module writeback
  import wb_pkg::*;
#(
  parameter int REG_NUM      = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  writeback_if.slave            wb_if,
  output wb_to_fetch_redirect_t wb_to_fetch_o,
  output logic                  flush_o,
  output logic [CNT_W-1:0]      retired_cnt_o
);

  alu_to_wb_req_t        req_q, req_d;
  wb_state_t             state_q, state_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  wb_to_fetch_redirect_t redirect_q, redirect_d;
  logic [CNT_W-1:0]      retired_cnt_q, retired_cnt_d;

  logic live;
  logic branch_take;
  logic commit_we;
  logic retire;

  always_comb begin
    live        = (state_q == WB_RUN);
    branch_take = live && req_q.fur_sig.pc_branch;
    commit_we   = live && !req_q.fur_sig.pc_branch && req_q.fur_sig.wb_wr;
    retire      = live && (req_q.fur_sig.wb_wr || req_q.fur_sig.pc_branch);
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    req_d         = wb_if.alu_to_wb_req;
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_d    = '0;
    retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, retire};

    if (branch_take) redirect_d = '{redirect: 1'b1, target: req_q.dst};

    unique case (state_q)
      WB_RUN: begin
        if (branch_take) begin
          state_d     = WB_FLUSH;
          flush_cnt_d = FLUSH_CNT_W'(FLUSH_CYCLES);
        end
      end
      WB_FLUSH: begin
        // The request sitting in req_q is squashed this cycle either way.
        if (flush_cnt_q == FLUSH_CNT_W'(1)) begin
          state_d     = WB_RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
        end
      end
      default: begin
        state_d     = WB_RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q         <= '0;
      state_q       <= WB_RUN;
      flush_cnt_q   <= '0;
      redirect_q    <= '0;
      retired_cnt_q <= '0;
    end else begin
      req_q         <= req_d;
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_q    <= redirect_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  wb_regfile #(
    .REG_NUM (REG_NUM)
  ) u_regfile (
    .clk         (clk),
    .rst         (rst),
    .we_i        (commit_we),
    .waddr_i     (req_q.fur_sig.reg_dst),
    .wdata_i     (req_q.dst),
    .rd_addr_1_i (wb_if.rd_addr_1),
    .rd_addr_2_i (wb_if.rd_addr_2),
    .rd_data_1_o (wb_if.rd_data_1),
    .rd_data_2_o (wb_if.rd_data_2)
  );

  assign wb_to_fetch_o = redirect_q;
  assign flush_o       = (state_q == WB_FLUSH);
  assign retired_cnt_o = retired_cnt_q;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed vector table, reset/wrap
// sequences and randomized traffic against a squash-window reference model.
module tb_writeback;
  import wb_pkg::*;

  localparam int CNT_W = 4;
  localparam int FC    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_if ifc ();
  wb_to_fetch_redirect_t fetch;
  logic                  flush;
  logic [CNT_W-1:0]      cnt;

  writeback #(
    .REG_NUM      (16),
    .FLUSH_CYCLES (FC),
    .CNT_W        (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_if         (ifc),
    .wb_to_fetch_o (fetch),
    .flush_o       (flush),
    .retired_cnt_o (cnt)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: architectural state plus "how many more requests to drop".
  imm_t           m_regs [16];
  alu_to_wb_req_t m_req;
  alu_to_wb_req_t cur_req;
  int             m_squash;
  int             m_retired;
  logic           m_redir;
  imm_t           m_tgt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic imm_t m_read(input reg_t a);
    if (a == '0) return '0;
    if (m_squash == 0 && m_req.fur_sig.wb_wr && !m_req.fur_sig.pc_branch &&
        m_req.fur_sig.reg_dst == a) return m_req.dst;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_req = '0; m_squash = 0; m_retired = 0; m_redir = 1'b0; m_tgt = '0;
  endtask

  task automatic model_edge(input alu_to_wb_req_t nxt);
    m_redir = 1'b0;
    m_tgt   = '0;
    if (m_squash > 0) begin
      m_squash--;
    end else if (m_req.fur_sig.pc_branch) begin
      m_redir = 1'b1; m_tgt = m_req.dst; m_squash = FC; m_retired++;
    end else if (m_req.fur_sig.wb_wr) begin
      m_retired++;
      if (m_req.fur_sig.reg_dst != '0) m_regs[m_req.fur_sig.reg_dst] = m_req.dst;
    end
    m_req = nxt;
  endtask

  function automatic alu_to_wb_req_t mk_req(input logic br, input logic wr, input reg_t rd, input imm_t d);
    alu_to_wb_req_t r;
    r.dst = d; r.fur_sig.pc_branch = br; r.fur_sig.wb_wr = wr; r.fur_sig.reg_dst = rd;
    return r;
  endfunction

  // Drives one cycle's inputs and compares everything against the model at negedge.
  task automatic drive(input alu_to_wb_req_t r, input reg_t a1, input reg_t a2);
    cur_req = r;
    ifc.alu_to_wb_req = r;
    ifc.rd_addr_1 = a1;
    ifc.rd_addr_2 = a2;
    #4;
    check("model_rd1",      ifc.rd_data_1, m_read(a1));
    check("model_rd2",      ifc.rd_data_2, m_read(a2));
    check("model_redirect", fetch.redirect, m_redir);
    check("model_target",   fetch.target, m_tgt);
    check("model_flush",    flush, (m_squash > 0));
    check("model_cnt",      cnt, m_retired % (1 << CNT_W));
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(cur_req);
    cyc++;
    #1;
  endtask

  typedef struct packed {
    logic       br;
    logic       wr;
    reg_t       rd;
    imm_t       dst;
    reg_t       a1;
    imm_t       e1;
    logic       e_redir;
    imm_t       e_tgt;
    logic       e_flush;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic br, input logic wr, input reg_t rd, input imm_t dst,
                              input reg_t a1, input imm_t e1, input logic er, input imm_t et,
                              input logic ef, input logic [3:0] ec);
    vec_t v;
    v.br = br; v.wr = wr; v.rd = rd; v.dst = dst; v.a1 = a1; v.e1 = e1;
    v.e_redir = er; v.e_tgt = et; v.e_flush = ef; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    alu_to_wb_req_t bub;
    alu_to_wb_req_t r;
    reg_t a1;
    bub = '0;
    rst = 1'b1;
    ifc.alu_to_wb_req = '0;
    ifc.rd_addr_1 = '0;
    ifc.rd_addr_2 = '0;
    cur_req = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;

    //         br wr rd  dst      a1  e1      redir tgt      flush cnt
    tbl[0]  = mk(0, 1, 3, 32'hA5,  3, 32'h0,  0, 32'h0,   0, 0);
    tbl[1]  = mk(0, 0, 0, 32'h0,   3, 32'hA5, 0, 32'h0,   0, 0);
    tbl[2]  = mk(0, 0, 0, 32'h0,   3, 32'hA5, 0, 32'h0,   0, 1);
    tbl[3]  = mk(0, 1, 0, 32'hFF,  0, 32'h0,  0, 32'h0,   0, 1);
    tbl[4]  = mk(0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 1);
    tbl[5]  = mk(1, 1, 5, 32'h40,  5, 32'h0,  0, 32'h0,   0, 2);
    tbl[6]  = mk(0, 1, 6, 32'h66,  5, 32'h0,  0, 32'h0,   0, 2);
    tbl[7]  = mk(0, 1, 7, 32'h77,  6, 32'h0,  1, 32'h40,  1, 3);
    tbl[8]  = mk(0, 1, 8, 32'h88,  7, 32'h0,  0, 32'h0,   1, 3);
    tbl[9]  = mk(0, 0, 0, 32'h0,   8, 32'h88, 0, 32'h0,   0, 3);
    tbl[10] = mk(0, 0, 0, 32'h0,   6, 32'h0,  0, 32'h0,   0, 4);
    tbl[11] = mk(1, 0, 0, 32'h100, 0, 32'h0,  0, 32'h0,   0, 4);
    tbl[12] = mk(1, 0, 0, 32'h200, 6, 32'h0,  0, 32'h0,   0, 4);
    tbl[13] = mk(0, 0, 0, 32'h0,   7, 32'h0,  1, 32'h100, 1, 5);
    tbl[14] = mk(0, 0, 0, 32'h0,   5, 32'h0,  0, 32'h0,   1, 5);
    tbl[15] = mk(0, 0, 0, 32'h0,   7, 32'h0,  0, 32'h0,   0, 5);
    tbl[16] = mk(0, 0, 0, 32'h0,   8, 32'h88, 0, 32'h0,   0, 5);

    for (int i = 0; i < 17; i++) begin
      drive(mk_req(tbl[i].br, tbl[i].wr, tbl[i].rd, tbl[i].dst), tbl[i].a1, reg_t'(i));
      check($sformatf("vec%0d_rd1", i),      ifc.rd_data_1, tbl[i].e1);
      check($sformatf("vec%0d_redirect", i), fetch.redirect, tbl[i].e_redir);
      check($sformatf("vec%0d_target", i),   fetch.target, tbl[i].e_tgt);
      check($sformatf("vec%0d_flush", i),    flush, tbl[i].e_flush);
      check($sformatf("vec%0d_cnt", i),      cnt, tbl[i].e_cnt);
      advance();
    end

    // Randomized traffic, roughly one branch in eight, reads biased toward the last write target.
    for (int i = 0; i < 400; i++) begin
      r.fur_sig.pc_branch = ($urandom_range(0, 7) == 0);
      r.fur_sig.wb_wr     = 1'($urandom_range(0, 1));
      r.fur_sig.reg_dst   = reg_t'($urandom);
      r.dst               = $urandom;
      if ($urandom_range(0, 9) == 0) r = '0;
      a1 = ($urandom_range(0, 2) == 0) ? cur_req.fur_sig.reg_dst : reg_t'($urandom);
      drive(r, a1, reg_t'($urandom));
      advance();
    end

    // Reset held for two cycles while a flush window is open.
    drive(mk_req(0, 1, 2, 32'h1234), 0, 0); advance();
    drive(mk_req(1, 0, 0, 32'h500), 0, 0);  advance();
    drive(bub, 0, 0);                       advance();
    drive(bub, 0, 0);
    check("pre_reset_flush", flush, 1'b1);
    advance();
    rst = 1'b1;
    drive(bub, 0, 0); advance();
    drive(bub, 0, 0); advance();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(bub, reg_t'(i), reg_t'(i + 8));
      check("reset_rd1",      ifc.rd_data_1, 32'h0);
      check("reset_rd2",      ifc.rd_data_2, 32'h0);
      check("reset_flush",    flush, 1'b0);
      check("reset_cnt",      cnt, 4'd0);
      check("reset_redirect", fetch.redirect, 1'b0);
      advance();
    end

    // Retired counter wrap: 15 writes reach the maximum, the 16th wraps to 0.
    for (int i = 0; i < 15; i++) begin
      drive(mk_req(0, 1, 1, imm_t'(i)), 1, 0);
      advance();
    end
    drive(bub, 1, 0); advance();
    drive(mk_req(0, 1, 0, 32'hFF), 0, 0);
    check("wrap_max", cnt, 4'd15);
    advance();
    drive(bub, 1, 0); advance();
    drive(bub, 1, 0);
    check("wrap_zero", cnt, 4'd0);
    check("wrap_r1",   ifc.rd_data_1, 32'd14);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
